// File: rtl/uart_16550_wb.sv
// uart_16550_wb: Wishbone-slave 16550-style UART. Register file, TX/RX FIFOs,
// baud tick generator and fixed-format 8N1 transmit/receive engines.
module uart_16550_wb #(
   parameter logic [31:0] BASE_ADDR  = 32'h1250_0000,
   parameter int unsigned REG_SHIFT  = 0,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd1,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   input  logic        WE_I,
   input  logic [3:0]  SEL_I,
   input  logic        STB_I,
   input  logic        CYC_I,
   output logic        ACK_O,
   output logic        INT_O,
   input  logic        RXD,
   output logic        TXD
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OW-1:0] OsLast = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] OsHalf = OW'(OVERSAMPLE / 2 - 1);
   localparam int unsigned TrigQ = (FIFO_DEPTH / 4 > 0) ? FIFO_DEPTH / 4 : 1;
   localparam int unsigned TrigH = (FIFO_DEPTH / 2 > 0) ? FIFO_DEPTH / 2 : 1;
   localparam int unsigned TrigF = (FIFO_DEPTH > 2) ? FIFO_DEPTH - 2 : 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Register file
   logic [1:0]  ier_q, fcr_trig_q;
   logic [7:0]  lcr_q, mcr_q, scr_q, dll_q, dlm_q, dat_q;
   logic        ack_q, int_q, ovr_q, thre_q, thre_d, tx_was_empty_q;
   // FIFOs
   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q, rx_count, rx_trig;
   // Baud and engines
   logic [15:0] baud_cnt_q, div_eff;
   state_e      tx_st_q, rx_st_q;
   logic [OW-1:0] tx_os_q, rx_os_q;
   logic [2:0]  tx_bit_q, rx_bit_q;
   logic [7:0]  tx_sh_q, rx_sh_q;
   logic        txd_q, rx_s1_q, rx_s2_q, rx_prev_q;

   logic [2:0]  idx;
   logic [7:0]  rdata, iir, lsr;
   logic        valid, wr, rd, dlab, tick;
   logic        thr_wr, dll_wr, dlm_wr, ier_wr, fcr_wr, rbr_rd, iir_rd, lsr_rd;
   logic        tx_empty, tx_full, tx_push, tx_pop;
   logic        rx_empty, rx_full, rx_pop, rx_push_req, rx_accept, rx_overrun;
   logic        rx_int, thre_int, rx_in;
   logic        unused_bits;

   assign idx    = ADR_I[REG_SHIFT+2:REG_SHIFT];
   assign valid  = STB_I & CYC_I & SEL_I[0] & (ADR_I[31:8] == BASE_ADDR[31:8]) & ~ack_q;
   assign wr     = valid & WE_I;
   assign rd     = valid & ~WE_I;
   assign dlab   = lcr_q[7];
   assign thr_wr = wr & (idx == 3'd0) & ~dlab;
   assign dll_wr = wr & (idx == 3'd0) & dlab;
   assign dlm_wr = wr & (idx == 3'd1) & dlab;
   assign ier_wr = wr & (idx == 3'd1) & ~dlab;
   assign fcr_wr = wr & (idx == 3'd2);
   assign rbr_rd = rd & (idx == 3'd0) & ~dlab;
   assign iir_rd = rd & (idx == 3'd2);
   assign lsr_rd = rd & (idx == 3'd5);

   assign tx_empty = tx_wr_q == tx_rd_q;
   assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
   assign rx_empty = rx_wr_q == rx_rd_q;
   assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
   assign rx_count = rx_wr_q - rx_rd_q;

   assign tx_push    = thr_wr & ~tx_full;
   assign tx_pop     = tick & ~tx_empty &
                       ((tx_st_q == StIdle) | ((tx_st_q == StStop) & (tx_os_q == OsLast)));
   assign rx_pop     = rbr_rd & ~rx_empty;
   assign rx_push_req = tick & (rx_st_q == StStop) & (rx_os_q == OsLast) & rx_s2_q;
   // A pop in the same cycle frees the slot the push needs.
   assign rx_accept  = rx_push_req & (~rx_full | rx_pop);
   assign rx_overrun = rx_push_req & rx_full & ~rx_pop;

   assign div_eff = ({dlm_q, dll_q} == 16'd0) ? 16'd1 : {dlm_q, dll_q};
   assign tick    = baud_cnt_q == div_eff - 16'd1;

   assign rx_int   = ier_q[0] & (rx_count >= rx_trig);
   assign thre_int = ier_q[1] & thre_q;
   assign iir      = rx_int ? 8'hC4 : (thre_int ? 8'hC2 : 8'hC1);
   assign lsr      = {1'b0, tx_empty & (tx_st_q == StIdle), tx_empty, 3'b000, ovr_q, ~rx_empty};
   assign rx_in    = mcr_q[4] ? txd_q : RXD;

   assign DAT_O = {24'h0, dat_q};
   assign ACK_O = ack_q;
   assign INT_O = int_q;
   assign TXD   = mcr_q[4] ? 1'b1 : txd_q;
   assign unused_bits = ^{ADR_I[7:0], DAT_I[31:8], SEL_I[3:1]};

   // RX trigger level from FCR[7:6]
   always_comb begin
      case (fcr_trig_q)
         2'd0:    rx_trig = (AW+1)'(1);
         2'd1:    rx_trig = (AW+1)'(TrigQ);
         2'd2:    rx_trig = (AW+1)'(TrigH);
         default: rx_trig = (AW+1)'(TrigF);
      endcase
   end

   // Read data mux
   always_comb begin
      rdata = 8'h00;
      case (idx)
         3'd0:    rdata = dlab ? dll_q : (rx_empty ? 8'h00 : rx_mem[rx_rd_q[AW-1:0]]);
         3'd1:    rdata = dlab ? dlm_q : {6'b0, ier_q};
         3'd2:    rdata = iir;
         3'd3:    rdata = lcr_q;
         3'd4:    rdata = mcr_q;
         3'd5:    rdata = lsr;
         3'd6:    rdata = 8'h00;
         default: rdata = scr_q;
      endcase
   end

   // THRE pending: clears on THR write or reporting IIR read, sets on empty transitions
   always_comb begin
      thre_d = thre_q;
      if (thr_wr || (iir_rd && iir == 8'hC2)) thre_d = 1'b0;
      if ((tx_empty && !tx_was_empty_q) || (ier_wr && DAT_I[1] && !ier_q[1] && tx_empty))
         thre_d = 1'b1;
   end

   // Bus response, control registers and interrupt output
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ack_q <= 1'b0;  dat_q <= 8'h00;  int_q <= 1'b0;
         ier_q <= 2'b00; lcr_q <= 8'h03;  mcr_q <= 8'h00; scr_q <= 8'h00;
         dll_q <= DIV_RESET[7:0]; dlm_q <= DIV_RESET[15:8]; fcr_trig_q <= 2'b00;
         ovr_q <= 1'b0;  thre_q <= 1'b0;  tx_was_empty_q <= 1'b1;
      end else begin
         ack_q <= valid;
         dat_q <= rd ? rdata : 8'h00;
         int_q <= rx_int | thre_int;
         thre_q <= thre_d;
         tx_was_empty_q <= tx_empty;
         if (ier_wr) ier_q <= DAT_I[1:0];
         if (dll_wr) dll_q <= DAT_I[7:0];
         if (dlm_wr) dlm_q <= DAT_I[7:0];
         if (fcr_wr) fcr_trig_q <= DAT_I[7:6];
         if (wr && idx == 3'd3) lcr_q <= DAT_I[7:0];
         if (wr && idx == 3'd4) mcr_q <= DAT_I[7:0];
         if (wr && idx == 3'd7) scr_q <= DAT_I[7:0];
         if (rx_overrun) ovr_q <= 1'b1;
         else if (lsr_rd || (fcr_wr && DAT_I[1])) ovr_q <= 1'b0;
      end
   end

   // FIFO pointers; a flush overrides any push/pop in the same cycle
   always_ff @(posedge CLK_I) begin
      if (RST_I || (fcr_wr && DAT_I[2])) begin
         tx_wr_q <= '0; tx_rd_q <= '0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
         if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      end
      if (RST_I || (fcr_wr && DAT_I[1])) begin
         rx_wr_q <= '0; rx_rd_q <= '0;
      end else begin
         if (rx_accept) rx_wr_q <= rx_wr_q + 1'b1;
         if (rx_pop)    rx_rd_q <= rx_rd_q + 1'b1;
      end
   end

   // FIFO storage
   always_ff @(posedge CLK_I) begin
      if (tx_push)   tx_mem[tx_wr_q[AW-1:0]] <= DAT_I[7:0];
      if (rx_accept) rx_mem[rx_wr_q[AW-1:0]] <= rx_sh_q;
   end

   // Baud tick counter, restarted on divisor writes
   always_ff @(posedge CLK_I) begin
      if (RST_I || dll_wr || dlm_wr || tick) baud_cnt_q <= 16'd0;
      else                                   baud_cnt_q <= baud_cnt_q + 16'd1;
   end

   // TX engine: 8N1, LSB first, back-to-back frames without idle gap
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         tx_st_q <= StIdle; tx_os_q <= '0; tx_bit_q <= 3'd0; tx_sh_q <= 8'h00; txd_q <= 1'b1;
      end else if (tick) begin
         case (tx_st_q)
            StIdle: if (!tx_empty) begin
               tx_sh_q <= tx_mem[tx_rd_q[AW-1:0]]; txd_q <= 1'b0; tx_os_q <= '0; tx_st_q <= StStart;
            end
            StStart: if (tx_os_q == OsLast) begin
               tx_os_q <= '0; tx_bit_q <= 3'd0; txd_q <= tx_sh_q[0]; tx_st_q <= StData;
            end else tx_os_q <= tx_os_q + 1'b1;
            StData: if (tx_os_q == OsLast) begin
               tx_os_q <= '0;
               if (tx_bit_q == 3'd7) begin
                  txd_q <= 1'b1; tx_st_q <= StStop;
               end else begin
                  txd_q <= tx_sh_q[1]; tx_sh_q <= tx_sh_q >> 1; tx_bit_q <= tx_bit_q + 3'd1;
               end
            end else tx_os_q <= tx_os_q + 1'b1;
            default: if (tx_os_q == OsLast) begin
               tx_os_q <= '0;
               if (!tx_empty) begin
                  tx_sh_q <= tx_mem[tx_rd_q[AW-1:0]]; txd_q <= 1'b0; tx_st_q <= StStart;
               end else tx_st_q <= StIdle;
            end else tx_os_q <= tx_os_q + 1'b1;
         endcase
      end
   end

   // RXD synchroniser plus previous sample for falling-edge detection
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_in; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      end
   end

   // RX engine: mid-bit sampling, glitch rejection on the start bit
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         rx_st_q <= StIdle; rx_os_q <= '0; rx_bit_q <= 3'd0; rx_sh_q <= 8'h00;
      end else begin
         case (rx_st_q)
            StIdle: if (rx_prev_q && !rx_s2_q) begin
               rx_os_q <= '0; rx_st_q <= StStart;
            end
            StStart: if (tick) begin
               if (rx_os_q == OsHalf) begin
                  rx_os_q <= '0; rx_bit_q <= 3'd0;
                  rx_st_q <= rx_s2_q ? StIdle : StData;
               end else rx_os_q <= rx_os_q + 1'b1;
            end
            StData: if (tick) begin
               if (rx_os_q == OsLast) begin
                  rx_os_q <= '0; rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_st_q <= StStop;
                  else rx_bit_q <= rx_bit_q + 3'd1;
               end else rx_os_q <= rx_os_q + 1'b1;
            end
            default: if (tick) begin
               if (rx_os_q == OsLast) begin
                  rx_os_q <= '0; rx_st_q <= StIdle;
               end else rx_os_q <= rx_os_q + 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_16550_wb.sv
// tb_uart_16550_wb: scenario tasks against a queue-based model of the UART.
module tb_uart_16550_wb;
   localparam int unsigned Depth   = 16;
   localparam int unsigned BitClks = 32;   // divisor 2 x 16 ticks per bit
   localparam logic [31:0] Base    = 32'h1250_0000;
   localparam logic [2:0]  RstIdx [8] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd4, 3'd6, 3'd7};
   localparam logic [7:0]  RstExp [8] = '{8'h00, 8'hC1, 8'h03, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] adr = '0, dat_i = '0, dat_o;
   logic        we_i = 1'b0, stb = 1'b0, cyc = 1'b0, ack_o, int_o, rxd = 1'b1, txd;
   logic [3:0]  sel_i = 4'h0;

   int checks = 0, failures = 0, bus_err = 0;
   logic        last_ack1, last_ack2;
   logic [31:0] last_dat, idle_dat;
   logic [7:0]  rx_model [$];
   logic        ovr_model;

   uart_16550_wb dut (
      .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat_o), .WE_I(we_i),
      .SEL_I(sel_i), .STB_I(stb), .CYC_I(cyc), .ACK_O(ack_o), .INT_O(int_o),
      .RXD(rxd), .TXD(txd)
   );

   always #5 clk = ~clk;

   task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [7:0] wdata, output logic [7:0] rdata);
      @(posedge clk); #1;
      adr = addr; dat_i = {24'hA5C396, wdata}; we_i = we; sel_i = sel; stb = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      last_ack1 = ack_o; last_dat = dat_o; rdata = dat_o[7:0];
      stb = 1'b0; cyc = 1'b0; we_i = 1'b0; sel_i = 4'h0;
      @(posedge clk); #1;
      last_ack2 = ack_o; idle_dat = dat_o;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [7:0] d);
      logic [7:0] junk;
      bus(1'b1, Base + 32'(idx), 4'h1, d, junk);
      if (last_ack1 !== 1'b1) bus_err++;
   endtask

   task automatic rd(input logic [2:0] idx, output logic [7:0] d);
      bus(1'b0, Base + 32'(idx), 4'h1, 8'h00, d);
      if (last_ack1 !== 1'b1) bus_err++;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_ok(input string name);
      checks++;
      if (bus_err !== 0) begin
         failures++; $display("FAIL %s_bus_ack missed=%0d exp=0", name, bus_err);
      end
      bus_err = 0;
   endtask

   task automatic test_reset();
      logic [7:0] r, s;
      rst = 1'b1; cycles(3); rst = 1'b0; #0;
      checks++; if (txd !== 1'b1) begin failures++; $display("FAIL rst_txd got=%b exp=1", txd); end
      checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL rst_int got=%b exp=0", int_o); end
      checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack_o); end
      checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat got=%h exp=0", dat_o); end
      for (int i = 0; i < 8; i++) begin
         rd(RstIdx[i], r);
         checks++;
         if (last_dat !== {24'h0, RstExp[i]}) begin
            failures++; $display("FAIL rst_reg%0d got=%h exp=%h", RstIdx[i], last_dat, RstExp[i]);
         end
         checks++;
         if (last_ack1 !== 1'b1 || last_ack2 !== 1'b0 || idle_dat !== 32'h0) begin
            failures++;
            $display("FAIL rst_ack_pulse got=%b%b/%h exp=10/0", last_ack1, last_ack2, idle_dat);
         end
      end
      s = 8'($urandom);
      wr(3'd7, s); rd(3'd7, r);
      checks++; if (r !== s) begin failures++; $display("FAIL scr_rw got=%h exp=%h", r, s); end
      bus(1'b0, 32'h1251_0005, 4'h1, 8'h00, r);
      checks++;
      if (last_ack1 !== 1'b0 || last_ack2 !== 1'b0) begin
         failures++; $display("FAIL nohit_ack got=%b%b exp=00", last_ack1, last_ack2);
      end
      bus(1'b1, Base + 32'd7, 4'h2, ~s, r);
      checks++; if (last_ack1 !== 1'b0) begin failures++; $display("FAIL sel0_ack got=%b exp=0", last_ack1); end
      rd(3'd7, r);
      checks++; if (r !== s) begin failures++; $display("FAIL sel0_nowrite got=%h exp=%h", r, s); end
      bus_ok("reset");
   endtask

   task automatic test_tx_frame();
      logic [7:0] b, r;
      logic [9:0] frame;
      int n;
      wr(3'd3, 8'h83); wr(3'd0, 8'h02); wr(3'd1, 8'h00);
      rd(3'd0, r);
      checks++; if (r !== 8'h02) begin failures++; $display("FAIL dll_rb got=%h exp=02", r); end
      wr(3'd3, 8'h03);
      for (int f = 0; f < 2; f++) begin
         b = (f == 0) ? 8'h55 : 8'($urandom);
         frame = {1'b1, b, 1'b0};
         wr(3'd0, b);
         n = 0;
         while (txd !== 1'b0 && n < 400) begin cycles(1); n++; end
         checks++;
         if (txd !== 1'b0) begin
            failures++; $display("FAIL tx_start_timeout got=%b exp=0", txd);
         end else begin
            cycles(BitClks / 2);
            for (int k = 0; k < 10; k++) begin
               checks++;
               if (txd !== frame[k]) begin
                  failures++; $display("FAIL tx_bit%0d byte=%h got=%b exp=%b", k, b, txd, frame[k]);
               end
               cycles(BitClks);
            end
         end
         n = 0; r = 8'h00;
         while (r[6] !== 1'b1 && n < 100) begin rd(3'd5, r); n++; end
         checks++; if (r !== 8'h60) begin failures++; $display("FAIL tx_lsr_idle got=%h exp=60", r); end
      end
      bus_ok("tx");
   endtask

   task automatic send_loop(input logic [7:0] b);
      wr(3'd0, b);
      if (rx_model.size() < Depth) rx_model.push_back(b);
      else ovr_model = 1'b1;
   endtask

   task automatic drain_check(input string name, input int cnt);
      logic [7:0] r, e;
      for (int i = 0; i < cnt; i++) begin
         e = rx_model.pop_front();
         rd(3'd0, r);
         checks++;
         if (r !== e) begin failures++; $display("FAIL %s_rbr%0d got=%h exp=%h", name, i, r, e); end
      end
   endtask

   task automatic test_loopback();
      logic [7:0] r, e;
      int bad = 0;
      wr(3'd2, 8'h06); wr(3'd4, 8'h10);
      rx_model.delete(); ovr_model = 1'b0;
      send_loop(8'hA5); send_loop(8'h3C);
      for (int i = 0; i < 750; i++) begin cycles(1); if (txd !== 1'b1) bad++; end
      checks++; if (bad != 0) begin failures++; $display("FAIL lb_txd_high got=%0d exp=0", bad); end
      e = {2'b01, 1'b1, 3'b000, ovr_model, rx_model.size() != 0};
      rd(3'd5, r);
      checks++; if (r !== e) begin failures++; $display("FAIL lb_lsr got=%h exp=%h", r, e); end
      drain_check("lb", 2);
      rd(3'd5, r);
      checks++; if (r !== 8'h60) begin failures++; $display("FAIL lb_lsr_empty got=%h exp=60", r); end
      bus_ok("loopback");
   endtask

   task automatic test_overrun();
      logic [7:0] r, e;
      int n;
      for (int i = 0; i < 10; i++) send_loop(8'($urandom));
      n = 0; r = 8'h00;
      while (r[5] !== 1'b1 && n < 1000) begin rd(3'd5, r); n++; end
      checks++; if (r[5] !== 1'b1) begin failures++; $display("FAIL ovr_tx_drain got=%h exp=1x1xxxxx", r); end
      for (int i = 0; i < Depth + 2 - 10; i++) send_loop(8'($urandom));
      cycles(3200);
      e = {2'b01, 1'b1, 3'b000, ovr_model, rx_model.size() != 0};
      rd(3'd5, r);
      checks++; if (r !== e) begin failures++; $display("FAIL ovr_lsr got=%h exp=%h", r, e); end
      e[1] = 1'b0;
      rd(3'd5, r);
      checks++; if (r !== e) begin failures++; $display("FAIL ovr_lsr_clr got=%h exp=%h", r, e); end
      drain_check("ovr", Depth);
      rd(3'd5, r);
      checks++; if (r !== 8'h60) begin failures++; $display("FAIL ovr_lsr_empty got=%h exp=60", r); end
      ovr_model = 1'b0;
      bus_ok("overrun");
   endtask

   task automatic test_interrupts();
      logic [7:0] r;
      int n;
      wr(3'd1, 8'h02);
      checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL thre_int got=%b exp=1", int_o); end
      rd(3'd2, r);
      checks++; if (r !== 8'hC2) begin failures++; $display("FAIL thre_iir got=%h exp=C2", r); end
      checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL thre_int_clr got=%b exp=0", int_o); end
      rd(3'd2, r);
      checks++; if (r !== 8'hC1) begin failures++; $display("FAIL thre_iir_clr got=%h exp=C1", r); end
      wr(3'd1, 8'h01); wr(3'd2, 8'h40);
      for (int i = 0; i < 4; i++) send_loop(8'($urandom));
      cycles(1100);
      checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL rx_int_early got=%b exp=0", int_o); end
      n = 0;
      while (int_o !== 1'b1 && n < 500) begin cycles(1); n++; end
      checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL rx_int_timeout got=%b exp=1", int_o); end
      rd(3'd2, r);
      checks++; if (r !== 8'hC4) begin failures++; $display("FAIL rx_iir got=%h exp=C4", r); end
      drain_check("int", 4);
      checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL rx_int_drop got=%b exp=0", int_o); end
      rd(3'd2, r);
      checks++; if (r !== 8'hC1) begin failures++; $display("FAIL rx_iir_drop got=%h exp=C1", r); end
      wr(3'd1, 8'h00); wr(3'd4, 8'h00); wr(3'd2, 8'h06);
      bus_ok("int");
   endtask

   task automatic test_reset_midframe();
      logic [7:0] r, b;
      logic [9:0] frame;
      int bad = 0;
      wr(3'd1, 8'h02);
      wr(3'd0, 8'($urandom));
      cycles(100);
      checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL mid_int_pre got=%b exp=1", int_o); end
      @(posedge clk); #1 rst = 1'b1;
      cycles(1);
      checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_txd got=%b exp=1", txd); end
      checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL mid_int got=%b exp=0", int_o); end
      rst = 1'b0;
      rd(3'd5, r);
      checks++; if (r !== 8'h60) begin failures++; $display("FAIL mid_lsr got=%h exp=60", r); end
      for (int i = 0; i < 400; i++) begin cycles(1); if (txd !== 1'b1) bad++; end
      checks++; if (bad != 0) begin failures++; $display("FAIL mid_txd_idle got=%0d exp=0", bad); end
      wr(3'd3, 8'h83); wr(3'd0, 8'h02); wr(3'd1, 8'h00); wr(3'd3, 8'h03);
      rxd = 1'b0; cycles(2); rxd = 1'b1;
      cycles(400);
      rd(3'd5, r);
      checks++; if (r !== 8'h60) begin failures++; $display("FAIL glitch_lsr got=%h exp=60", r); end
      b = 8'($urandom);
      frame = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin rxd = frame[k]; cycles(BitClks); end
      cycles(20);
      rd(3'd5, r);
      checks++; if (r !== 8'h61) begin failures++; $display("FAIL pin_rx_lsr got=%h exp=61", r); end
      rd(3'd0, r);
      checks++; if (r !== b) begin failures++; $display("FAIL pin_rx_rbr got=%h exp=%h", r, b); end
      bus_ok("midframe");
   endtask

   initial begin
      ovr_model = 1'b0;
      test_reset();
      test_tx_frame();
      test_loopback();
      test_overrun();
      test_interrupts();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_16550_wb.md
Name: uart_16550_wb

Overview:
- Parametrised Wishbone-slave UART: 8250/16550-style register file plus working TX/RX FIFOs, a baud generator and 8N1 serial engines.
- Sits on the SoC Wishbone bus as a console/peripheral UART. Drives the TXD pin, samples the RXD pin and raises INT_O to the interrupt controller.

Parameters:
- BASE_ADDR, 32'h1250_0000, bus base address; decode compares ADR_I[31:8] against BASE_ADDR[31:8].
- REG_SHIFT, 0, register stride is 1<<REG_SHIFT bytes; register index = ADR_I[REG_SHIFT+2:REG_SHIFT].
- FIFO_DEPTH, 16, depth of each of the TX and RX FIFOs; must be a power of 2, from 2 to 256.
- DIV_RESET, 16'd1, divisor latch reset value.
- OVERSAMPLE, 16, baud ticks per bit; must be a power of 2.

Ports:
- CLK_I  in  1  clock; all logic is on the rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- ADR_I  in  32  byte address.
- DAT_I  in  32  write data; the register byte is bits [7:0].
- DAT_O  out  32  read data, {24'b0, reg}.
- WE_I  in  1  write enable.
- SEL_I  in  4  byte select; an access is ignored unless SEL_I[0]=1.
- STB_I  in  1  strobe.
- CYC_I  in  1  bus cycle.
- ACK_O  out  1  access acknowledge.
- INT_O  out  1  level interrupt.
- RXD  in  1  serial input; idle high.
- TXD  out  1  serial output; idle high.

Behaviour:
- Reset values:
  - DAT_O=0, ACK_O=0, INT_O=0, TXD=1.
  - IER=0, LCR=8'h03, MCR=0, SCR=0, divisor=DIV_RESET.
  - Both FIFOs empty; both engines IDLE.
  - LSR reads 8'h60; IIR reads 8'hC1.
- Reset mid-frame aborts the frame and forces TXD=1 in the next cycle.
- Bus access:
  - A valid access is STB_I & CYC_I & address hit & !ACK_O.
  - ACK_O is high for exactly one cycle, the cycle after a valid access; DAT_O is valid in that same cycle.
  - Register side effects happen once, in the access cycle.
  - A non-hit or SEL_I[0]=0 access gets no ACK.
  - DAT_O holds 0 when it is not acking a read.
- Register map by index (DLAB=LCR[7]):
  - 0: read RBR (pops RX FIFO; returns 0 when empty); write THR (pushes TX FIFO; write is dropped when full). With DLAB=1, read/write DLL.
  - 1: IER, bits [1:0] only (bit 0 RX data available, bit 1 THR empty). With DLAB=1, DLM.
  - 2: read IIR; write FCR. FCR bit 1 flushes RX FIFO and clears overrun; bit 2 flushes TX FIFO; bits [7:6] set the RX trigger level.
  - 3: LCR, read/write. Only DLAB is functional; frame format is fixed 8N1.
  - 4: MCR. Bit 4 enables loopback: RX engine input = TX engine output, and TXD is held at 1.
  - 5: LSR, read-only.
    - bit 0: RX FIFO non-empty.
    - bit 1: overrun, sticky; cleared on LSR read.
    - bit 5: TX FIFO empty.
    - bit 6: TX FIFO empty and TX engine idle.
  - 6: MSR, reads 0.
  - 7: SCR, read/write scratch.
- FIFOs:
  - Circular buffers with log2(FIFO_DEPTH)+1-bit head/tail pointers; full = MSBs differ and LSBs equal.
  - Simultaneous push and pop on the same FIFO are both honoured and the count is unchanged.
  - A push to a full RX FIFO discards the new byte and sets overrun.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- RX trigger level:
  - FCR[7:6] = 0/1/2/3 gives 1, FIFO_DEPTH/4, FIFO_DEPTH/2, FIFO_DEPTH-2.
  - The level is clamped to at least 1.
- Baud generator:
  - A 16-bit counter emits a 1-cycle tick every max(divisor,1) clocks.
  - Bit time = OVERSAMPLE ticks.
  - Writing DLL or DLM reloads the counter to 0.
- TX engine:
  - States IDLE, START, DATA, STOP.
  - IDLE: when the TX FIFO is non-empty, pop a byte on the next tick and enter START with TXD=0.
  - DATA: shift 8 bits LSB-first.
  - STOP: drive TXD=1 for one bit.
  - After STOP, go back to START if the FIFO is non-empty, otherwise IDLE. Back-to-back frames have no idle gap.
- RX engine:
  - States IDLE, START, DATA, STOP.
  - RXD passes through a 2-flop synchroniser first.
  - A falling edge in IDLE enters START.
  - START: sample at tick OVERSAMPLE/2. If the line is high it was a glitch; return to IDLE.
  - DATA: sample the 8 bits at their mid-points.
  - STOP: if the stop bit samples high, push the byte; otherwise discard it (framing error, no flag). Then return to IDLE.
- Interrupts:
  - rx_int = IER[0] & (RX count >= trigger level).
  - thre_int = IER[1] & thre_pending.
  - thre_pending sets on the TX FIFO transition to empty and when IER[1] is written 0->1 while the FIFO is empty. It clears on an IIR read that reports it, or on a THR write.
  - IIR value: 8'hC4 if rx_int, else 8'hC2 if thre_int, else 8'hC1. RX has priority.
  - INT_O = rx_int | thre_int, registered, so 1 cycle of latency.

Test Plan:
1. Release reset, then read indices 1, 2, 3, 5 -> 0x00, 0xC1, 0x03, 0x60. TXD stays 1. Every ACK_O pulse is 1 cycle wide.
2. Set DLAB, DLL=2, DLM=0, clear DLAB; write THR=0x55 -> TXD shows start 0, bits 1,0,1,0,1,0,1,0, stop 1. Each bit is 32 clocks. LSR bit 6 returns to 1 after the stop bit.
3. Loopback: MCR=0x10; write 0xA5 then 0x3C -> after 2 frames, LSR bit 0 = 1. RBR reads 0xA5 then 0x3C; then LSR bit 0 = 0.
4. With loopback, write FIFO_DEPTH+2 bytes without reading -> RX keeps FIFO_DEPTH bytes. LSR reads 0x63 (bit 1 set), then the next LSR read has bit 1 = 0. The first FIFO_DEPTH bytes read back in order.
5. IER=0x02 with TX empty -> INT_O=1 and IIR=0xC2; after that IIR read, INT_O=0 and IIR=0xC1. Then IER=0x01, FCR=0x40 (trigger 4), loopback 4 bytes -> INT_O rises after the 4th stop bit and IIR=0xC4.
6. Assert RST_I mid-TX frame -> next cycle TXD=1, INT_O=0, LSR=0x60. A 1-tick low glitch on RXD pushes no byte into the RX FIFO.
